spi_dac_rx: RTL and testbench

Receive-side model of the vector DAC serial link. Samples the 3-wire stream (`cs`, `dclk`, `data`) produced by the line-draw controller and decodes 16-bit MCP4922-style frames into the X (channel A) and Y (channel B) beam coordinates the physical DAC would output. Used in loopback benches and on-FPGA self-check to confirm that a commanded point reached the DAC pins intact.

---
 rtl/spi_dac_rx.sv | 211 +++++++++++++++++++++
 tb/tb_spi_dac_rx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_dac_rx.sv
// -----------------------------------------------------------------------------
// spi_dac_rx
//   Receive-side model of the vector DAC serial link. It samples the 3-wire
//   stream (cs, dclk, data) and decodes 16-bit MCP4922-style frames into the
//   X (channel A) and Y (channel B) codes that the physical DAC would output.
//
// Ports
//   clk, reset   system clock; synchronous active-high reset
//   cs_pin       frame select, active-low (asynchronous to clk)
//   clk_pin      serial clock; data is sampled on its rising edge (async)
//   data_pin     serial data, MSB first (async)
//   dac_x/dac_y  last accepted channel-A / channel-B code
//   x_stb/y_stb  one-cycle pulse when dac_x / dac_y updates
//   point_valid  one-cycle pulse on a B load that follows at least one A load
//   shdn_a/b     channel is in shutdown (last frame had SHDN_n = 0)
//   frame_err    one-cycle pulse for a frame whose bit count is not WORD_BITS
// -----------------------------------------------------------------------------
module spi_dac_rx #(
    parameter int WORD_BITS   = 16,
    parameter int DATA_BITS   = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cs_pin,
    input  logic                 clk_pin,
    input  logic                 data_pin,
    output logic [DATA_BITS-1:0] dac_x,
    output logic [DATA_BITS-1:0] dac_y,
    output logic                 x_stb,
    output logic                 y_stb,
    output logic                 point_valid,
    output logic                 shdn_a,
    output logic                 shdn_b,
    output logic                 frame_err
);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, DECODE} state_t;

    localparam int CNT_W   = $clog2(WORD_BITS + 2);
    localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(WORD_BITS);
    localparam logic [CNT_W-1:0]   CNT_SAT    = CNT_W'(WORD_BITS + 1);
    localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(SYNC_STAGES);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] dclk_sync_q, dclk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   cs_prev_q, cs_prev_d;
    logic                   dclk_prev_q, dclk_prev_d;
    logic [FLUSH_W-1:0]     flush_q, flush_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WORD_BITS-1:0]   shift_q, shift_d;
    logic                   a_seen_q, a_seen_d;
    logic [DATA_BITS-1:0]   dac_x_q, dac_x_d, dac_y_q, dac_y_d;
    logic                   x_stb_q, x_stb_d, y_stb_q, y_stb_d;
    logic                   point_valid_q, point_valid_d;
    logic                   shdn_a_q, shdn_a_d, shdn_b_q, shdn_b_d;
    logic                   frame_err_q, frame_err_d;

    logic cs_s, dclk_s, data_s;
    logic cs_fall, cs_rise, dclk_rise;
    logic                 frame_ch, frame_on;
    logic [DATA_BITS-1:0] frame_code;

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign dclk_s    = dclk_sync_q[SYNC_STAGES-1];
    assign data_s    = data_sync_q[SYNC_STAGES-1];
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign cs_rise   = ~cs_prev_q & cs_s;
    assign dclk_rise = ~dclk_prev_q & dclk_s;

    // Frame fields: [15] channel, [12] SHDN_n, [11:0] code; BUF and GA_n ignored.
    assign frame_ch   = shift_q[WORD_BITS-1];
    assign frame_on   = shift_q[DATA_BITS];
    assign frame_code = shift_q[DATA_BITS-1:0];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], cs_pin};
        dclk_sync_d   = {dclk_sync_q[SYNC_STAGES-2:0], clk_pin};
        data_sync_d   = {data_sync_q[SYNC_STAGES-2:0], data_pin};
        cs_prev_d     = cs_s;
        dclk_prev_d   = dclk_s;
        state_d       = state_q;
        flush_d       = flush_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        a_seen_d      = a_seen_q;
        dac_x_d       = dac_x_q;
        dac_y_d       = dac_y_q;
        shdn_a_d      = shdn_a_q;
        shdn_b_d      = shdn_b_q;
        x_stb_d       = 1'b0;
        y_stb_d       = 1'b0;
        point_valid_d = 1'b0;
        frame_err_d   = 1'b0;

        unique case (state_q)
            WAIT_IDLE: begin
                // The sync chain still holds its reset values for SYNC_STAGES
                // cycles; wait until it reflects the real pin before trusting
                // cs high, otherwise a frame already running at reset release
                // would look like a fresh cs fall.
                if (flush_q != FLUSH_DONE) begin
                    flush_d = flush_q + 1'b1;
                end else if (cs_s) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (cs_fall) begin
                    cnt_d   = '0;
                    shift_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // cs rise wins over a coincident dclk edge.
                if (cs_rise) begin
                    state_d = DECODE;
                end else if (dclk_rise) begin
                    shift_d = {shift_q[WORD_BITS-2:0], data_s};
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DECODE: begin
                state_d = IDLE;
                if (cnt_q != CNT_FULL) begin
                    frame_err_d = 1'b1;
                end else if (!frame_ch) begin
                    shdn_a_d = ~frame_on;
                    if (frame_on) begin
                        dac_x_d  = frame_code;
                        x_stb_d  = 1'b1;
                        a_seen_d = 1'b1;
                    end
                end else begin
                    shdn_b_d = ~frame_on;
                    if (frame_on) begin
                        dac_y_d = frame_code;
                        y_stb_d = 1'b1;
                        if (a_seen_q) begin
                            point_valid_d = 1'b1;
                            a_seen_d      = 1'b0;
                        end
                    end
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the values from
        // before this edge, independent of statement order.
        if (reset) begin
            state_q       <= WAIT_IDLE;
            cs_sync_q     <= '1;
            dclk_sync_q   <= '0;
            data_sync_q   <= '0;
            cs_prev_q     <= 1'b1;
            dclk_prev_q   <= 1'b0;
            flush_q       <= '0;
            cnt_q         <= '0;
            shift_q       <= '0;
            a_seen_q      <= 1'b0;
            dac_x_q       <= '0;
            dac_y_q       <= '0;
            x_stb_q       <= 1'b0;
            y_stb_q       <= 1'b0;
            point_valid_q <= 1'b0;
            shdn_a_q      <= 1'b0;
            shdn_b_q      <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cs_sync_q     <= cs_sync_d;
            dclk_sync_q   <= dclk_sync_d;
            data_sync_q   <= data_sync_d;
            cs_prev_q     <= cs_prev_d;
            dclk_prev_q   <= dclk_prev_d;
            flush_q       <= flush_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            a_seen_q      <= a_seen_d;
            dac_x_q       <= dac_x_d;
            dac_y_q       <= dac_y_d;
            x_stb_q       <= x_stb_d;
            y_stb_q       <= y_stb_d;
            point_valid_q <= point_valid_d;
            shdn_a_q      <= shdn_a_d;
            shdn_b_q      <= shdn_b_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign dac_x       = dac_x_q;
    assign dac_y       = dac_y_q;
    assign x_stb       = x_stb_q;
    assign y_stb       = y_stb_q;
    assign point_valid = point_valid_q;
    assign shdn_a      = shdn_a_q;
    assign shdn_b      = shdn_b_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_dac_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_dac_rx
//   Directed bench for spi_dac_rx. A frame-level model predicts every output
//   on every cycle (each decoded frame takes effect 4 clk edges after its cs
//   rise); literal checks pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_spi_dac_rx;

    localparam int PH  = 3;   // clk cycles per dclk phase and cs setup
    localparam int GAP = 5;   // cs-high gap between frames
    localparam int LAT = 4;   // cs rise to visible outputs

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs_pin = 1'b1;
    logic        clk_pin = 1'b0;
    logic        data_pin = 1'b0;
    logic [11:0] dac_x, dac_y;
    logic        x_stb, y_stb, point_valid, shdn_a, shdn_b, frame_err;

    spi_dac_rx dut (
        .clk(clk), .reset(reset), .cs_pin(cs_pin), .clk_pin(clk_pin),
        .data_pin(data_pin), .dac_x(dac_x), .dac_y(dac_y), .x_stb(x_stb),
        .y_stb(y_stb), .point_valid(point_valid), .shdn_a(shdn_a),
        .shdn_b(shdn_b), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          at;
        logic [15:0] word;
        int          nbits;
    } ev_t;

    ev_t         pending[$];
    logic [23:0] pairs[$];
    int total = 0, bad = 0, cyc = 0;
    int x_cnt = 0, y_cnt = 0, pv_cnt = 0, err_cnt = 0;
    int last_xs_cyc = -1, last_ys_cyc = -1, last_pv_cyc = -1, last_rise_cyc = 0;

    // model state
    logic [11:0] m_x, m_y;
    logic m_sa, m_sb, m_aseen, m_xs, m_ys, m_pv, m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Apply one complete frame to the model using the frame rules directly.
    task automatic model_frame(input ev_t ev);
        logic [15:0] w;
        w = ev.word;
        if (ev.nbits != 16) begin
            m_err = 1'b1;
        end else if (w[15] == 1'b0) begin
            m_sa = ~w[12];
            if (w[12]) begin
                m_x = w[11:0]; m_xs = 1'b1; m_aseen = 1'b1;
            end
        end else begin
            m_sb = ~w[12];
            if (w[12]) begin
                m_y = w[11:0]; m_ys = 1'b1;
                if (m_aseen) begin
                    m_pv = 1'b1; m_aseen = 1'b0;
                end
            end
        end
    endtask

    // Compare process: one pass per clk cycle, 1 time unit after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            m_xs = 1'b0; m_ys = 1'b0; m_pv = 1'b0; m_err = 1'b0;
            if (reset) begin
                m_x = '0; m_y = '0; m_sa = 1'b0; m_sb = 1'b0; m_aseen = 1'b0;
                pending.delete();
            end else if (pending.size() > 0 && pending[0].at == cyc) begin
                model_frame(pending.pop_front());
            end
            check("dac_x", dac_x, m_x);
            check("dac_y", dac_y, m_y);
            check("shdn_a", shdn_a, m_sa);
            check("shdn_b", shdn_b, m_sb);
            check("x_stb", x_stb, m_xs);
            check("y_stb", y_stb, m_ys);
            check("point_valid", point_valid, m_pv);
            check("frame_err", frame_err, m_err);
            if (x_stb === 1'b1) begin x_cnt++; last_xs_cyc = cyc; end
            if (y_stb === 1'b1) begin y_cnt++; last_ys_cyc = cyc; end
            if (point_valid === 1'b1) begin
                pv_cnt++; last_pv_cyc = cyc;
                pairs.push_back({dac_x, dac_y});
            end
            if (frame_err === 1'b1) err_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Send nbits of 'bits' MSB first. abort_after > 0 pulses reset after that
    // many bits; such a frame must produce nothing.
    task automatic send(input logic [31:0] bits, input int nbits, input int abort_after);
        ev_t ev;
        cs_pin = 1'b0;
        tick(PH);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (abort_after > 0 && (nbits - 1 - i) == abort_after) begin
                reset = 1'b1;
                tick(2);
                reset = 1'b0;
            end
            clk_pin  = 1'b0;
            data_pin = bits[i];
            tick(PH);
            clk_pin = 1'b1;
            tick(PH);
        end
        clk_pin = 1'b0;
        tick(PH);
        cs_pin = 1'b1;
        last_rise_cyc = cyc;
        if (abort_after == 0) begin
            ev.at = cyc + LAT; ev.word = bits[15:0]; ev.nbits = nbits;
            pending.push_back(ev);
        end
        tick(GAP);
    endtask

    logic [11:0] px[8] = '{12'd0, 12'd4095, 12'd4095, 12'd0, 12'd0, 12'd4095, 12'd0, 12'd2048};
    logic [11:0] py[8] = '{12'd0, 12'd0, 12'd4095, 12'd4095, 12'd0, 12'd4095, 12'd0, 12'd2048};

    initial begin
        int x0, y0, e0, p0;
        tick(3);
        reset = 1'b0;
        tick(2);
        check("rst_dac_x", dac_x, 0);
        check("rst_dac_y", dac_y, 0);
        check("rst_shdn_a", shdn_a, 0);
        check("rst_shdn_b", shdn_b, 0);
        check("rst_pulses", {x_stb, y_stb, point_valid, frame_err}, 0);

        // Single A frame: X full scale, latency 4.
        send(32'h3FFF, 16, 0);
        check("t1_dac_x", dac_x, 12'hFFF);
        check("t1_x_latency", last_xs_cyc - last_rise_cyc, LAT);
        check("t1_x_cnt", x_cnt, 1);
        check("t1_y_cnt", y_cnt, 0);

        // A then B makes a point; a lone B does not.
        send(32'h3FFF, 16, 0);
        send(32'hB190, 16, 0);
        check("t2_dac_y", dac_y, 400);
        check("t2_pv_cnt", pv_cnt, 1);
        check("t2_pv_with_y", last_pv_cyc - last_ys_cyc, 0);
        send(32'hB190, 16, 0);
        check("t2_y_cnt", y_cnt, 2);
        check("t2_pv_lone_b", pv_cnt, 1);

        // Short and long frames.
        send(32'h3AAA, 15, 0);
        send(32'h13AAA, 17, 0);
        check("t3_err_cnt", err_cnt, 2);
        check("t3_dac_x", dac_x, 12'hFFF);
        check("t3_dac_y", dac_y, 12'h190);

        // Shutdown frame then normal A frame.
        send(32'h2ABC, 16, 0);
        check("t4_shdn_a", shdn_a, 1);
        check("t4_dac_x_hold", dac_x, 12'hFFF);
        send(32'h3123, 16, 0);
        check("t4_shdn_a_off", shdn_a, 0);
        check("t4_dac_x", dac_x, 12'h123);

        // Reset after 8 bits, released while cs is still low.
        x0 = x_cnt; y0 = y_cnt; e0 = err_cnt; p0 = pv_cnt;
        send(32'h3456, 16, 8);
        check("t5_dac_x", dac_x, 0);
        check("t5_dac_y", dac_y, 0);
        check("t5_shdn", {shdn_a, shdn_b}, 0);
        check("t5_no_pulses", (x_cnt - x0) + (y_cnt - y0) + (err_cnt - e0) + (pv_cnt - p0), 0);
        send(32'h3555, 16, 0);
        check("t5_next_dac_x", dac_x, 12'h555);
        check("t5_next_x_cnt", x_cnt - x0, 1);

        // Loopback-style square/diagonal pattern.
        pairs.delete();
        for (int i = 0; i < 8; i++) begin
            send({16'h0, 4'h3, px[i]}, 16, 0);
            send({16'h0, 4'hB, py[i]}, 16, 0);
        end
        check("t6_point_count", pairs.size(), 8);
        for (int i = 0; i < 8 && i < pairs.size(); i++) begin
            check($sformatf("t6_point%0d", i), pairs[i], {px[i], py[i]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
